keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, synchronized row sampling, per-sweep
// classification and a debounce/hold FSM that emits one key_valid per press.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no key accepted; waiting for a sweep with exactly one contact
// S_DEBOUNCE | candidate seen; counting identical single-contact sweeps
// S_HELD     | key accepted; counting empty sweeps until release is accepted
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;

  // sweep contact classes
  localparam logic [1:0] C_NONE   = 2'd0;
  localparam logic [1:0] C_SINGLE = 2'd1;
  localparam logic [1:0] C_MULTI  = 2'd2;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       col_q;
  logic [1:0]       acc_cnt_q;
  logic [3:0]       acc_code_q;
  logic             tick;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  assign tick = (div_q == DIV_LAST);

  // Per-column reading and its merge into the running sweep classification
  logic [3:0] pressed;
  logic [1:0] col_cnt, row_idx, sum_cnt;
  logic [3:0] sum_code;

  always_comb begin
    pressed = ~row_s2_q;
    row_idx = 2'd0;
    case (pressed)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    if (pressed == 4'b0000)  col_cnt = C_NONE;
    else if ($onehot(pressed)) col_cnt = C_SINGLE;
    else                     col_cnt = C_MULTI;

    if (acc_cnt_q == C_NONE) begin
      sum_cnt  = col_cnt;
      sum_code = key_map(row_idx, col_idx_q);
    end else begin
      sum_cnt  = (col_cnt == C_NONE) ? acc_cnt_q : C_MULTI;
      sum_code = acc_code_q;
    end
  end

  logic sweep_done;
  assign sweep_done = tick && (col_idx_q == 2'd3);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      acc_cnt_q  <= C_NONE;
      acc_code_q <= 4'h0;
    end else if (tick) begin
      div_q      <= '0;
      col_idx_q  <= col_idx_q + 2'd1;
      col_q      <= ~(4'b0001 << (col_idx_q + 2'd1));
      acc_cnt_q  <= sweep_done ? C_NONE : sum_cnt;
      acc_code_q <= sweep_done ? 4'h0 : sum_code;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rel_q, rel_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= 4'h0;
      rel_q       <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (sweep_done) begin
      case (state_q)
        S_IDLE: begin
          if (sum_cnt == C_SINGLE) begin
            state_d = S_DEBOUNCE;
            cand_d  = sum_code;
            cnt_d   = 4'd1;
          end
        end
        S_DEBOUNCE: begin
          if (sum_cnt == C_SINGLE && sum_code == cand_q) begin
            // counter never exceeds the threshold, so it cannot wrap
            if (cnt_q + 4'd1 >= DEB_N) begin
              state_d     = S_HELD;
              cnt_d       = 4'd0;
              rel_d       = 4'd0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end
        S_HELD: begin
          if (sum_cnt == C_NONE) begin
            if (rel_q + 4'd1 >= DEB_N) begin
              state_d    = S_IDLE;
              rel_d      = 4'd0;
              key_held_d = 1'b0;
            end else begin
              rel_d = rel_q + 4'd1;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16 clk per sweep);
// a behavioural keypad matrix drives row from col and the set of pressed keys.
module tb_keypad_scanner;

  logic       clk;
  logic       clr_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c
  int tests, fails;
  int pulse_cnt, mon_err, tmo_err;
  logic prev_valid;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .clr_n(clr_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  initial begin
    pulse_cnt = 0; mon_err = 0; prev_valid = 1'b0;
  end

  always @(negedge clk) begin
    if ($countones(~col) != 1) begin
      mon_err++;
      $display("FAIL col_onehot: col=%b required exactly one low bit", col);
    end
    if (key_valid && prev_valid) begin
      mon_err++;
      $display("FAIL valid_width: key_valid high on two consecutive clks, required one");
    end
    if (key_valid) pulse_cnt++;
    prev_valid = key_valid;
  end

  task automatic wait_sweep_start();
    int n;
    n = 0;
    while (col !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
    while (col !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) tmo_err++;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (col !== 4'b1110) begin fails++; $display("FAIL reset_col: got %b want 1110", col); end
    tests++;
    if (key_code !== 4'h0) begin fails++; $display("FAIL reset_code: got %h want 0", key_code); end
    tests++;
    if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    tests++;
    if (key_held !== 1'b0) begin fails++; $display("FAIL reset_held: got %b want 0", key_held); end
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (col !== 4'b1110) begin fails++; $display("FAIL post_reset_col: got %b want 1110", col); end
    @(negedge clk);
    tests++;
    if (col !== 4'b1101) begin fails++; $display("FAIL first_advance_col: got %b want 1101", col); end
  endtask

  task automatic test_single_key();
    int p0, lat;
    bit got;
    p0 = pulse_cnt; got = 0; lat = 0;
    pressed = 16'h0; pressed[5] = 1'b1;      // key 5: r1 c1
    for (int i = 0; i < 96 && !got; i++) begin
      @(negedge clk); lat++;
      if (pulse_cnt != p0) got = 1;
    end
    tests++;
    if (!got || lat < 32 || lat > 72) begin
      fails++; $display("FAIL k5_latency: got pulse=%0d after %0d clk want pulse in 32..72 clk", got, lat);
    end
    tests++;
    if (key_code !== 4'h5) begin fails++; $display("FAIL k5_code: got %h want 5", key_code); end
    tests++;
    if (key_held !== 1'b1) begin fails++; $display("FAIL k5_held: got %b want 1", key_held); end
    repeat (160) @(negedge clk);
    tests++;
    if (pulse_cnt != p0 + 1) begin fails++; $display("FAIL k5_retrigger: got %0d pulses want 1", pulse_cnt - p0); end
    pressed = 16'h0;
    got = 0; lat = 0;
    for (int i = 0; i < 96 && !got; i++) begin
      @(negedge clk); lat++;
      if (key_held === 1'b0) got = 1;
    end
    tests++;
    if (!got || lat < 32 || lat > 80) begin
      fails++; $display("FAIL k5_release: got held_low=%0d after %0d clk want low in 32..80 clk", got, lat);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    wait_sweep_start();
    pressed = 16'h0; pressed[15] = 1'b1;     // key D: r3 c3
    repeat (32) @(negedge clk);
    pressed = 16'h0;
    repeat (16) @(negedge clk);
    pressed[15] = 1'b1;
    repeat (40) @(negedge clk);
    tests++;
    if (pulse_cnt != p0) begin fails++; $display("FAIL kd_early: got %0d pulses want 0", pulse_cnt - p0); end
    repeat (16) @(negedge clk);
    tests++;
    if (pulse_cnt != p0 + 1) begin fails++; $display("FAIL kd_pulse: got %0d pulses want 1", pulse_cnt - p0); end
    tests++;
    if (key_code !== 4'hD) begin fails++; $display("FAIL kd_code: got %h want D", key_code); end
    pressed = 16'h0;
    repeat (80) @(negedge clk);
  endtask

  task automatic test_multi();
    int p0;
    p0 = pulse_cnt;
    pressed = 16'h0; pressed[0] = 1'b1; pressed[1] = 1'b1;   // keys 1 and 2
    repeat (160) @(negedge clk);
    tests++;
    if (pulse_cnt != p0) begin fails++; $display("FAIL multi_pulse: got %0d pulses want 0", pulse_cnt - p0); end
    tests++;
    if (key_code !== 4'hD) begin fails++; $display("FAIL multi_code: got %h want D", key_code); end
    tests++;
    if (key_held !== 1'b0) begin fails++; $display("FAIL multi_held: got %b want 0", key_held); end
    pressed = 16'h0;
    repeat (32) @(negedge clk);
  endtask

  task automatic test_second_key();
    int p0;
    bit got;
    p0 = pulse_cnt;
    pressed = 16'h0; pressed[8] = 1'b1;      // key 7: r2 c0
    repeat (80) @(negedge clk);
    tests++;
    if (pulse_cnt != p0 + 1 || key_code !== 4'h7) begin
      fails++; $display("FAIL k7_accept: got %0d pulses code %h want 1 pulse code 7", pulse_cnt - p0, key_code);
    end
    pressed[9] = 1'b1;                       // add key 8: r2 c1
    repeat (64) @(negedge clk);
    pressed[9] = 1'b0;
    repeat (64) @(negedge clk);
    tests++;
    if (pulse_cnt != p0 + 1) begin fails++; $display("FAIL k8_ignored: got %0d pulses want 1", pulse_cnt - p0); end
    tests++;
    if (key_held !== 1'b1 || key_code !== 4'h7) begin
      fails++; $display("FAIL k7_still_held: got held=%b code=%h want held=1 code=7", key_held, key_code);
    end
    pressed = 16'h0;
    got = 0;
    for (int i = 0; i < 96 && !got; i++) begin
      @(negedge clk);
      if (key_held === 1'b0) got = 1;
    end
    tests++;
    if (!got) begin fails++; $display("FAIL k7_release: got held=%b want 0", key_held); end
    repeat (16) @(negedge clk);
    pressed[9] = 1'b1;
    repeat (80) @(negedge clk);
    tests++;
    if (pulse_cnt != p0 + 2 || key_code !== 4'h8) begin
      fails++; $display("FAIL k8_accept: got %0d pulses code %h want 2 pulses code 8", pulse_cnt - p0, key_code);
    end
    pressed = 16'h0;
    repeat (80) @(negedge clk);
  endtask

  task automatic test_reset_held();
    int p0;
    pressed = 16'h0; pressed[12] = 1'b1;     // key 0: r3 c0
    repeat (80) @(negedge clk);
    tests++;
    if (key_held !== 1'b1) begin fails++; $display("FAIL k0_held: got %b want 1", key_held); end
    clr_n = 1'b0;
    #1;
    tests++;
    if (key_held !== 1'b0 || key_valid !== 1'b0 || col !== 4'b1110 || key_code !== 4'h0) begin
      fails++; $display("FAIL k0_reset: got held=%b valid=%b col=%b code=%h want 0 0 1110 0",
                        key_held, key_valid, col, key_code);
    end
    @(negedge clk);
    clr_n = 1'b1;
    p0 = pulse_cnt;
    repeat (40) @(negedge clk);
    tests++;
    if (pulse_cnt != p0) begin fails++; $display("FAIL k0_early: got %0d pulses want 0", pulse_cnt - p0); end
    repeat (16) @(negedge clk);
    tests++;
    if (pulse_cnt != p0 + 1) begin fails++; $display("FAIL k0_pulse: got %0d pulses want 1", pulse_cnt - p0); end
    tests++;
    if (key_code !== 4'h0 || key_held !== 1'b1) begin
      fails++; $display("FAIL k0_code: got code=%h held=%b want 0 1", key_code, key_held);
    end
    pressed = 16'h0;
    repeat (80) @(negedge clk);
  endtask

  task automatic test_invariants();
    tests++;
    if (mon_err != 0) begin fails++; $display("FAIL invariants: got %0d violations want 0", mon_err); end
    tests++;
    if (tmo_err != 0) begin fails++; $display("FAIL sweep_sync: got %0d timeouts want 0", tmo_err); end
  endtask

  initial begin
    tests = 0; fails = 0; tmo_err = 0;
    pressed = 16'h0;
    clr_n = 1'b1;
    #1;
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_second_key();
    test_reset_held();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
